// File: rtl/neural_soc_cfg_pkg.sv
// Shared types and constants for the boot-time configuration sequencer.
package neural_soc_cfg_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned STALL_W = 8;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_ID      = 2'd1;
    localparam logic [ERR_W-1:0] ERR_TS      = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [ADDR_W-1:0] SYSID_BASE_DEF  = 8'h00;
    localparam logic [ADDR_W-1:0] CFG_BASE_DEF    = 8'h10;
    localparam logic [DATA_W-1:0] EXPECTED_ID_DEF = 32'h0000_0000;
    localparam logic [DATA_W-1:0] EXPECTED_TS_DEF = 32'd1480282281;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_WR_CFG,
        ST_DONE,
        ST_FAIL
    } state_e;

    // One Avalon transfer request as handed from the sequencer to the engine.
    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } avm_req_t;

endpackage

// File: rtl/neural_soc_avm_xfer.sv
// Single-transfer Avalon-MM master engine: launches one request when idle,
// holds it through waitrequest and aborts after TIMEOUT stalled cycles.
module neural_soc_avm_xfer
    import neural_soc_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_go_c,
    input  avm_req_t          req,
    input  logic              m_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              xfer_done_c,
    output logic              xfer_timeout_c
);

    logic [STALL_W-1:0] stall_cnt;
    logic               strobe;

    assign strobe         = m_read | m_write;
    assign xfer_done_c    = strobe & ~m_waitrequest;
    assign xfer_timeout_c = strobe & m_waitrequest & (stall_cnt == STALL_W'(TIMEOUT - 1));

    // A new request is only accepted with the strobe low, which forces the gap cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_address   <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_writedata <= '0;
            stall_cnt   <= '0;
        end else if (strobe) begin
            if (xfer_done_c || xfer_timeout_c) begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end else if (req_go_c) begin
            m_address   <= req.addr;
            m_read      <= req.rd;
            m_write     <= ~req.rd;
            m_writedata <= req.wdata;
            stall_cnt   <= '0;
        end
    end

endmodule

// File: rtl/neural_soc_cfg_sequencer.sv
// Boot-time sequencer: verifies the sysid slave, then streams the config
// table into the accelerator and reports done or a sticky error code.
module neural_soc_cfg_sequencer
    import neural_soc_cfg_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID = EXPECTED_ID_DEF,
    parameter logic [DATA_W-1:0] EXPECTED_TS = EXPECTED_TS_DEF,
    parameter logic [ADDR_W-1:0] SYSID_BASE  = SYSID_BASE_DEF,
    parameter logic [ADDR_W-1:0] CFG_BASE    = CFG_BASE_DEF,
    parameter int unsigned       NUM_CFG     = 8,
    parameter int unsigned       TIMEOUT     = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest,
    output logic [IDX_W-1:0]  cfg_index,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  error
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CFG - 1);

    state_e   state;
    avm_req_t xfer_req;
    logic     xfer_go_c;
    logic     xfer_done_c;
    logic     xfer_timeout_c;

    // Request for the transfer belonging to the current (or just-starting) phase.
    always_comb begin
        xfer_go_c      = 1'b0;
        xfer_req.rd    = 1'b1;
        xfer_req.addr  = SYSID_BASE;
        xfer_req.wdata = '0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_FAIL: xfer_go_c = start;
            ST_RD_ID:                  xfer_go_c = 1'b1;
            ST_RD_TS: begin
                xfer_go_c     = 1'b1;
                xfer_req.addr = SYSID_BASE + ADDR_W'(1);
            end
            ST_WR_CFG: begin
                xfer_go_c      = 1'b1;
                xfer_req.rd    = 1'b0;
                xfer_req.addr  = CFG_BASE + ADDR_W'(cfg_index);
                xfer_req.wdata = cfg_data;
            end
            default: xfer_go_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= ERR_NONE;
            cfg_index <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state     <= ST_RD_ID;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= ERR_NONE;
                        cfg_index <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (xfer_done_c) begin
                        if (m_readdata == EXPECTED_ID) begin
                            state <= ST_RD_TS;
                        end else begin
                            state <= ST_FAIL;
                            busy  <= 1'b0;
                            error <= ERR_ID;
                        end
                    end else if (xfer_timeout_c) begin
                        state <= ST_FAIL;
                        busy  <= 1'b0;
                        error <= ERR_TIMEOUT;
                    end
                end
                ST_RD_TS: begin
                    if (xfer_done_c) begin
                        if (m_readdata == EXPECTED_TS) begin
                            state <= ST_WR_CFG;
                        end else begin
                            state <= ST_FAIL;
                            busy  <= 1'b0;
                            error <= ERR_TS;
                        end
                    end else if (xfer_timeout_c) begin
                        state <= ST_FAIL;
                        busy  <= 1'b0;
                        error <= ERR_TIMEOUT;
                    end
                end
                ST_WR_CFG: begin
                    if (xfer_done_c) begin
                        if (cfg_index == LAST_K) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cfg_index <= cfg_index + IDX_W'(1);
                        end
                    end else if (xfer_timeout_c) begin
                        state <= ST_FAIL;
                        busy  <= 1'b0;
                        error <= ERR_TIMEOUT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    neural_soc_avm_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_go_c       (xfer_go_c),
        .req            (xfer_req),
        .m_waitrequest  (m_waitrequest),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .xfer_done_c    (xfer_done_c),
        .xfer_timeout_c (xfer_timeout_c)
    );

endmodule
